dram_bridge: RTL and testbench

- Sits between the d16 core's data-memory port and sdram_controller; feeds the controller's address/req_read/req_write/data_in and consumes its data_out/data_out_valid.
- Converts 16-bit halfword core accesses into 32-bit DRAM word accesses.
- Performs read-modify-write for halfword stores, because the controller has no byte/halfword mask.
- Holds a one-entry 32-bit read buffer, so consecutive halfword reads of the same DRAM word cost one DRAM access.

---
 rtl/dram_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_dram_bridge.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_bridge.sv
// dram_bridge: adapts the d16 core's 16-bit halfword data-memory port to the
// 32-bit word interface of sdram_controller.
//
// It keeps a single-word read buffer so that back-to-back halfword loads of
// the same DRAM word cost only one DRAM access. Halfword stores are done as
// read-modify-write, because the controller cannot mask byte or halfword lanes.
//
// Ports:
//   clk, rst         system clock; synchronous active-high reset
//   core_req/we      access request and direction, held by the core until core_ack
//   core_addr        halfword address: [24:1] is the DRAM word, [0] is the lane
//   core_wdata       store data
//   core_rdata       load data, valid only while core_ack is high
//   core_ack         one-cycle completion pulse
//   flush            invalidates the read buffer
//   dram_addr        word address to the controller
//   dram_req_read    read request to the controller
//   dram_req_write   write request to the controller
//   dram_data_in     write data to the controller
//   dram_data_out    read data from the controller
//   dram_data_valid  one-cycle read-data strobe from the controller
module dram_bridge #(
  parameter int unsigned WRITE_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [24:0] core_addr,
  input  logic [15:0] core_wdata,
  output logic [15:0] core_rdata,
  output logic        core_ack,
  input  logic        flush,
  output logic [23:0] dram_addr,
  output logic        dram_req_read,
  output logic        dram_req_write,
  output logic [31:0] dram_data_in,
  input  logic [31:0] dram_data_out,
  input  logic        dram_data_valid
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_HOLD, ACK} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(WRITE_HOLD);

  state_t      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [23:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        store_pending_q, store_pending_d;
  logic        flush_pending_q, flush_pending_d;
  logic        lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [23:0] dram_addr_q, dram_addr_d;
  logic        dram_req_read_q, dram_req_read_d;
  logic        dram_req_write_q, dram_req_write_d;
  logic [31:0] dram_data_in_q, dram_data_in_d;
  logic        core_ack_q, core_ack_d;
  logic [15:0] core_rdata_q, core_rdata_d;
  logic        hit;

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic        lane,
                                             input logic [15:0] data);
    return lane ? {data, word[15:0]} : {word[31:16], data};
  endfunction

  function automatic logic [15:0] select_lane(input logic [31:0] word,
                                              input logic        lane);
    return lane ? word[31:16] : word[15:0];
  endfunction

  // A flush arriving in the same cycle as a request wins, so that request misses.
  assign hit = buf_valid_q && !flush && (buf_tag_q == core_addr[24:1]);

  // Next-state and output logic. Every output is registered, so each one is
  // computed for the state being entered. Requests are only accepted in IDLE,
  // and the core address, lane and data are latched there so that later
  // states do not depend on the core keeping them stable.
  always_comb begin
    state_d          = state_q;
    buf_valid_d      = buf_valid_q;
    buf_tag_d        = buf_tag_q;
    buf_data_d       = buf_data_q;
    store_pending_d  = store_pending_q;
    flush_pending_d  = flush_pending_q;
    lane_d           = lane_q;
    wdata_d          = wdata_q;
    hold_cnt_d       = hold_cnt_q;
    dram_addr_d      = dram_addr_q;
    dram_req_read_d  = dram_req_read_q;
    dram_req_write_d = dram_req_write_q;
    dram_data_in_d   = dram_data_in_q;
    core_ack_d       = 1'b0;
    core_rdata_d     = 16'h0000;

    case (state_q)
      IDLE: begin
        if (flush) buf_valid_d = 1'b0;
        if (core_req) begin
          lane_d          = core_addr[0];
          wdata_d         = core_wdata;
          store_pending_d = core_we;
          dram_addr_d     = core_addr[24:1];
          if (hit && core_we) begin
            dram_data_in_d   = merge_lane(buf_data_q, core_addr[0], core_wdata);
            dram_req_write_d = 1'b1;
            hold_cnt_d       = HOLD_INIT;
            state_d          = WR_HOLD;
          end else if (hit) begin
            core_ack_d   = 1'b1;
            core_rdata_d = select_lane(buf_data_q, core_addr[0]);
            state_d      = ACK;
          end else begin
            // Both a load miss and the read phase of a store miss start here.
            dram_req_read_d = 1'b1;
            state_d         = RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        if (flush) flush_pending_d = 1'b1;
        if (dram_data_valid) begin
          buf_data_d      = dram_data_out;
          buf_tag_d       = dram_addr_q;
          buf_valid_d     = 1'b1;
          dram_req_read_d = 1'b0;
          if (store_pending_q) begin
            dram_data_in_d   = merge_lane(dram_data_out, lane_q, wdata_q);
            dram_req_write_d = 1'b1;
            hold_cnt_d       = HOLD_INIT;
            state_d          = WR_HOLD;
          end else begin
            core_ack_d   = 1'b1;
            core_rdata_d = select_lane(dram_data_out, lane_q);
            state_d      = ACK;
          end
        end
      end

      // The controller has no write handshake, so a write is treated as
      // complete once the request has been held for WRITE_HOLD cycles.
      WR_HOLD: begin
        if (flush) flush_pending_d = 1'b1;
        if (hold_cnt_q <= 4'd1) begin
          dram_req_write_d = 1'b0;
          buf_data_d       = dram_data_in_q;
          buf_tag_d        = dram_addr_q;
          buf_valid_d      = 1'b1;
          core_ack_d       = 1'b1;
          state_d          = ACK;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end

      // Any flush held back during the access takes effect on the way to IDLE.
      ACK: begin
        if (flush || flush_pending_q) buf_valid_d = 1'b0;
        flush_pending_d = 1'b0;
        store_pending_d = 1'b0;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register. Reset drops any in-flight DRAM request and issues no ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      buf_valid_q      <= 1'b0;
      buf_tag_q        <= '0;
      buf_data_q       <= '0;
      store_pending_q  <= 1'b0;
      flush_pending_q  <= 1'b0;
      lane_q           <= 1'b0;
      wdata_q          <= '0;
      hold_cnt_q       <= '0;
      dram_addr_q      <= '0;
      dram_req_read_q  <= 1'b0;
      dram_req_write_q <= 1'b0;
      dram_data_in_q   <= '0;
      core_ack_q       <= 1'b0;
      core_rdata_q     <= '0;
    end else begin
      state_q          <= state_d;
      buf_valid_q      <= buf_valid_d;
      buf_tag_q        <= buf_tag_d;
      buf_data_q       <= buf_data_d;
      store_pending_q  <= store_pending_d;
      flush_pending_q  <= flush_pending_d;
      lane_q           <= lane_d;
      wdata_q          <= wdata_d;
      hold_cnt_q       <= hold_cnt_d;
      dram_addr_q      <= dram_addr_d;
      dram_req_read_q  <= dram_req_read_d;
      dram_req_write_q <= dram_req_write_d;
      dram_data_in_q   <= dram_data_in_d;
      core_ack_q       <= core_ack_d;
      core_rdata_q     <= core_rdata_d;
    end
  end

  assign dram_addr      = dram_addr_q;
  assign dram_req_read  = dram_req_read_q;
  assign dram_req_write = dram_req_write_q;
  assign dram_data_in   = dram_data_in_q;
  assign core_ack       = core_ack_q;
  assign core_rdata     = core_rdata_q;

endmodule

// File: tb/tb_dram_bridge.sv
// Directed testbench for dram_bridge. It includes a small in-line model of the
// SDRAM controller's read side: the model returns a programmed word after a
// programmed number of cycles in which dram_req_read is high.
module tb_dram_bridge;

  localparam int WRITE_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [24:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic [15:0] core_rdata;
  logic        core_ack;
  logic        flush = 1'b0;
  logic [23:0] dram_addr;
  logic        dram_req_read;
  logic        dram_req_write;
  logic [31:0] dram_data_in;
  logic [31:0] dram_data_out = '0;
  logic        dram_data_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations.
  int          r_cycles;
  int          r_rd_reqs;
  int          r_wr_cycles;
  logic        r_ack;
  logic [15:0] r_rdata;
  logic [23:0] r_rd_addr;
  logic [23:0] r_wr_addr;
  logic [31:0] r_wr_data;

  dram_bridge #(.WRITE_HOLD(WRITE_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .core_req(core_req),
    .core_we(core_we),
    .core_addr(core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_ack(core_ack),
    .flush(flush),
    .dram_addr(dram_addr),
    .dram_req_read(dram_req_read),
    .dram_req_write(dram_req_write),
    .dram_data_in(dram_data_in),
    .dram_data_out(dram_data_out),
    .dram_data_valid(dram_data_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // The read and write requests must never be high together.
  always @(negedge clk) begin
    if (rst === 1'b0) checkOutput("rd_wr_exclusive", 32'(dram_req_read && dram_req_write), 32'd0);
  end

  // Runs one core access. Cycle 1 is the cycle in which core_req is first
  // driven, and r_cycles is the cycle in which core_ack is seen. flush_at
  // pulses flush during that cycle; 0 means no flush.
  task automatic applyStimulus(input logic we, input logic [24:0] addr,
                               input logic [15:0] wdata, input int rd_lat,
                               input logic [31:0] rd_data, input int flush_at);
    int  n;
    int  rd_seen;
    bit  prev_rd;
    bit  served;
    r_cycles = 0; r_rd_reqs = 0; r_wr_cycles = 0; r_ack = 1'b0;
    r_rdata = '0; r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    flush = (flush_at == 1);
    n = 1; rd_seen = 0; prev_rd = 1'b0; served = 1'b0;
    while (!r_ack && n < 40) begin
      @(negedge clk);
      n++;
      flush = (n == flush_at);
      dram_data_valid = 1'b0;
      if (dram_req_read) begin
        if (!prev_rd) r_rd_reqs++;
        r_rd_addr = dram_addr;
        rd_seen++;
        if (rd_seen == rd_lat && !served) begin
          dram_data_valid = 1'b1;
          dram_data_out   = rd_data;
          served          = 1'b1;
        end
      end
      prev_rd = dram_req_read;
      if (dram_req_write) begin
        r_wr_cycles++;
        r_wr_addr = dram_addr;
        r_wr_data = dram_data_in;
      end
      if (core_ack) begin
        r_ack    = 1'b1;
        r_cycles = n;
        r_rdata  = core_rdata;
      end
    end
    core_req = 1'b0; flush = 1'b0; dram_data_valid = 1'b0;
    checkOutput("ack_seen", 32'(r_ack), 32'd1);
    @(negedge clk);
    checkOutput("ack_one_cycle", 32'(core_ack), 32'd0);
  endtask

  initial begin
    // Reset: every output starts at zero.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_dram_addr", 32'(dram_addr), 32'd0);
    checkOutput("rst_req_read", 32'(dram_req_read), 32'd0);
    checkOutput("rst_req_write", 32'(dram_req_write), 32'd0);
    checkOutput("rst_data_in", dram_data_in, 32'd0);
    checkOutput("rst_ack", 32'(core_ack), 32'd0);
    checkOutput("rst_rdata", 32'(core_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Load miss, then a hit in the other lane of the same word.
    applyStimulus(1'b0, 25'h000010, 16'h0, 5, 32'hBEEF1234, 0);
    checkOutput("lmiss_rd_reqs", r_rd_reqs, 1);
    checkOutput("lmiss_rd_addr", 32'(r_rd_addr), 32'h000008);
    checkOutput("lmiss_rdata", 32'(r_rdata), 32'h1234);
    checkOutput("lmiss_latency", r_cycles, 7);
    checkOutput("lmiss_no_write", r_wr_cycles, 0);
    applyStimulus(1'b0, 25'h000011, 16'h0, 1, 32'h0, 0);
    checkOutput("lhit_rd_reqs", r_rd_reqs, 0);
    checkOutput("lhit_rdata", 32'(r_rdata), 32'hBEEF);
    checkOutput("lhit_latency", r_cycles, 2);

    // Store miss: read-modify-write into the upper lane.
    applyStimulus(1'b1, 25'h000021, 16'hAAAA, 3, 32'h11112222, 0);
    checkOutput("smiss_rd_reqs", r_rd_reqs, 1);
    checkOutput("smiss_rd_addr", 32'(r_rd_addr), 32'h000010);
    checkOutput("smiss_wr_cycles", r_wr_cycles, WRITE_HOLD);
    checkOutput("smiss_wr_addr", 32'(r_wr_addr), 32'h000010);
    checkOutput("smiss_wr_data", r_wr_data, 32'hAAAA2222);
    checkOutput("smiss_latency", r_cycles, 3 + WRITE_HOLD + 2);
    checkOutput("smiss_rdata", 32'(r_rdata), 32'h0);
    applyStimulus(1'b0, 25'h000020, 16'h0, 1, 32'h0, 0);
    checkOutput("smiss_follow_rd_reqs", r_rd_reqs, 0);
    checkOutput("smiss_follow_rdata", 32'(r_rdata), 32'h2222);

    // Store hit into the lower lane; the buffer must hold the merged word.
    applyStimulus(1'b1, 25'h000020, 16'h5555, 1, 32'h0, 0);
    checkOutput("shit_rd_reqs", r_rd_reqs, 0);
    checkOutput("shit_wr_cycles", r_wr_cycles, WRITE_HOLD);
    checkOutput("shit_wr_data", r_wr_data, 32'hAAAA5555);
    checkOutput("shit_latency", r_cycles, 6);
    applyStimulus(1'b0, 25'h000021, 16'h0, 1, 32'h0, 0);
    checkOutput("shit_follow_rd_reqs", r_rd_reqs, 0);
    checkOutput("shit_follow_rdata", 32'(r_rdata), 32'hAAAA);

    // Flush in IDLE forces a second DRAM read of the same word.
    applyStimulus(1'b0, 25'h000010, 16'h0, 2, 32'hBEEF1234, 0);
    checkOutput("fl_first_rd_reqs", r_rd_reqs, 1);
    checkOutput("fl_first_latency", r_cycles, 4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 25'h000010, 16'h0, 2, 32'hBEEF1234, 0);
    checkOutput("fl_idle_rd_reqs", r_rd_reqs, 1);
    checkOutput("fl_idle_rdata", 32'(r_rdata), 32'h1234);

    // A flush in the same cycle as the request wins, so the access misses.
    applyStimulus(1'b0, 25'h000010, 16'h0, 2, 32'hBEEF1234, 1);
    checkOutput("fl_same_rd_reqs", r_rd_reqs, 1);

    // A flush during WR_HOLD lets the write finish, then the next load misses.
    applyStimulus(1'b1, 25'h000011, 16'h7777, 1, 32'h0, 3);
    checkOutput("fl_wr_rd_reqs", r_rd_reqs, 0);
    checkOutput("fl_wr_cycles", r_wr_cycles, WRITE_HOLD);
    checkOutput("fl_wr_addr", 32'(r_wr_addr), 32'h000008);
    checkOutput("fl_wr_data", r_wr_data, 32'h77771234);
    checkOutput("fl_wr_latency", r_cycles, 6);
    applyStimulus(1'b0, 25'h000011, 16'h0, 2, 32'h77771234, 0);
    checkOutput("fl_wr_next_rd_reqs", r_rd_reqs, 1);
    checkOutput("fl_wr_next_rdata", 32'(r_rdata), 32'h7777);

    // Reset during RD_WAIT: the read request drops, no ack follows, and a late
    // data strobe must not fill the buffer.
    core_req = 1'b1; core_we = 1'b0; core_addr = 25'h000040;
    repeat (2) @(negedge clk);
    checkOutput("mrst_rd_active", 32'(dram_req_read), 32'd1);
    rst = 1'b1; core_req = 1'b0;
    @(negedge clk);
    checkOutput("mrst_rd_dropped", 32'(dram_req_read), 32'd0);
    checkOutput("mrst_no_ack", 32'(core_ack), 32'd0);
    rst = 1'b0;
    dram_data_valid = 1'b1; dram_data_out = 32'hDEADBEEF;
    @(negedge clk);
    dram_data_valid = 1'b0;
    checkOutput("mrst_late_no_ack", 32'(core_ack), 32'd0);
    @(negedge clk);
    checkOutput("mrst_late_no_req", 32'(dram_req_read), 32'd0);
    applyStimulus(1'b0, 25'h000040, 16'h0, 1, 32'h1234CAFE, 0);
    checkOutput("mrst_next_rd_reqs", r_rd_reqs, 1);
    checkOutput("mrst_next_rd_addr", 32'(r_rd_addr), 32'h000020);
    checkOutput("mrst_next_rdata", 32'(r_rdata), 32'hCAFE);

    // A data strobe in IDLE is ignored: no ack, and the buffer is unchanged.
    dram_data_valid = 1'b1; dram_data_out = 32'hFFFFFFFF;
    @(negedge clk);
    dram_data_valid = 1'b0;
    checkOutput("spur_no_ack", 32'(core_ack), 32'd0);
    checkOutput("spur_no_read", 32'(dram_req_read), 32'd0);
    checkOutput("spur_no_write", 32'(dram_req_write), 32'd0);
    @(negedge clk);
    checkOutput("spur_no_ack_2", 32'(core_ack), 32'd0);
    applyStimulus(1'b0, 25'h000041, 16'h0, 1, 32'h0, 0);
    checkOutput("spur_hit_rd_reqs", r_rd_reqs, 0);
    checkOutput("spur_hit_latency", r_cycles, 2);
    checkOutput("spur_hit_rdata", 32'(r_rdata), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
